// File: rtl/serial_link_xcvr.sv
// Full-duplex source-clocked serial transceiver: WIDTH-bit frames sent MSB-first
// plus an even-parity bit, with synchronised receive, parity check and stall timeout.
module serial_link_xcvr #(
  parameter int WIDTH      = 256,
  parameter int CLK_DIV    = 4,
  parameter int RX_TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] tx_data,
  output logic             tx_busy,
  output logic             tx_done,
  output logic             ser_clk_out,
  output logic             ser_data_out,
  input  logic             ser_rdy_in,
  input  logic             ser_clk_in,
  input  logic             ser_data_in,
  input  logic             rx_enable,
  output logic             ser_rdy_out,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             rx_err
);

  // TX states
  // state      | meaning
  // S_IDLE     | waiting for start
  // S_WAIT_RDY | frame latched, waiting for peer ready
  // S_SHIFT    | clocking out WIDTH data bits then parity
  // S_DONE     | one-cycle completion pulse

  localparam int CW = $clog2(WIDTH + 2);
  localparam int TW = $clog2(RX_TIMEOUT + 1);
  localparam int DW = $clog2(CLK_DIV);

  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH);
  localparam logic [CW-1:0] RX_FULL  = CW'(WIDTH + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(RX_TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT_RDY, S_SHIFT, S_DONE} tx_state_e;

  logic rdy_s1_q, rdy_s2_q;
  logic clk_s1_q, clk_s2_q, clk_s3_q;
  logic dat_s1_q, dat_s2_q;
  logic clk_rise;

  tx_state_e       state_q, state_d;
  logic [WIDTH:0]  sh_q, sh_d;
  logic [CW-1:0]   idx_q, idx_d;
  logic [DW-1:0]   div_q, div_d;
  logic            sclk_q, sclk_d;
  logic            sdat_q, sdat_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic [WIDTH:0]   rx_sh_q, rx_sh_d;
  logic [CW-1:0]    rx_cnt_q, rx_cnt_d;
  logic [TW-1:0]    to_q, to_d;
  logic [WIDTH-1:0] rx_data_q, rx_data_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;
  logic             rdy_out_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rdy_s1_q <= 1'b0;
      rdy_s2_q <= 1'b0;
      clk_s1_q <= 1'b0;
      clk_s2_q <= 1'b0;
      clk_s3_q <= 1'b0;
      dat_s1_q <= 1'b0;
      dat_s2_q <= 1'b0;
    end else begin
      rdy_s1_q <= ser_rdy_in;
      rdy_s2_q <= rdy_s1_q;
      clk_s1_q <= ser_clk_in;
      clk_s2_q <= clk_s1_q;
      clk_s3_q <= clk_s2_q;
      dat_s1_q <= ser_data_in;
      dat_s2_q <= dat_s1_q;
    end
  end

  // Data travels through the same sync depth as the clock, so it is aligned at the edge.
  assign clk_rise = clk_s2_q & ~clk_s3_q;

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    idx_d   = idx_q;
    div_d   = div_q;
    sclk_d  = sclk_q;
    sdat_d  = sdat_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          sh_d    = {tx_data, ^tx_data};
          busy_d  = 1'b1;
          state_d = S_WAIT_RDY;
        end
      end
      S_WAIT_RDY: begin
        sclk_d = 1'b0;
        if (rdy_s2_q) begin
          state_d = S_SHIFT;
          idx_d   = '0;
          div_d   = '0;
          sdat_d  = sh_q[WIDTH];
        end
      end
      S_SHIFT: begin
        if (div_q == DIV_LAST) begin
          div_d  = '0;
          sclk_d = ~sclk_q;
          if (sclk_q) begin
            if (idx_q == LAST_IDX) begin
              state_d = S_DONE;
              done_d  = 1'b1;
              busy_d  = 1'b0;
              sdat_d  = 1'b0;
            end else begin
              idx_d  = idx_q + CW'(1);
              sh_d   = {sh_q[WIDTH-1:0], 1'b0};
              sdat_d = sh_q[WIDTH-1];
            end
          end
        end else begin
          div_d = div_q + DW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      sh_q    <= '0;
      idx_q   <= '0;
      div_q   <= '0;
      sclk_q  <= 1'b0;
      sdat_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      idx_q   <= idx_d;
      div_q   <= div_d;
      sclk_q  <= sclk_d;
      sdat_q  <= sdat_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    rx_sh_d   = rx_sh_q;
    rx_cnt_d  = rx_cnt_q;
    to_d      = to_q;
    rx_data_d = rx_data_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;
    if (!rx_enable) begin
      rx_cnt_d = '0;
      to_d     = '0;
    end else if (rx_cnt_q == RX_FULL) begin
      rx_cnt_d = '0;
      to_d     = '0;
      if (!(^rx_sh_q)) begin
        rx_data_d = rx_sh_q[WIDTH:1];
        valid_d   = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end else if (clk_rise) begin
      rx_sh_d  = {rx_sh_q[WIDTH-1:0], dat_s2_q};
      rx_cnt_d = rx_cnt_q + CW'(1);
      to_d     = '0;
    end else if (rx_cnt_q != '0) begin
      if (to_q == TO_LAST) begin
        rx_cnt_d = '0;
        to_d     = '0;
      end else begin
        to_d = to_q + TW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_sh_q   <= '0;
      rx_cnt_q  <= '0;
      to_q      <= '0;
      rx_data_q <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      rdy_out_q <= 1'b0;
    end else begin
      rx_sh_q   <= rx_sh_d;
      rx_cnt_q  <= rx_cnt_d;
      to_q      <= to_d;
      rx_data_q <= rx_data_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
      rdy_out_q <= rx_enable;
    end
  end

  assign tx_busy      = busy_q;
  assign tx_done      = done_q;
  assign ser_clk_out  = sclk_q;
  assign ser_data_out = sdat_q;
  assign ser_rdy_out  = rdy_out_q;
  assign rx_data      = rx_data_q;
  assign rx_valid     = valid_q;
  assign rx_err       = err_q;

endmodule

// File: tb/tb_serial_link_xcvr.sv
// Directed bench for serial_link_xcvr in loopback, with an external driver
// for corrupted and stalled frames; received frames are checked against a queue.
module tb_serial_link_xcvr;
  localparam int W  = 8;
  localparam int CD = 2;
  localparam int TO = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, start, rx_enable;
  logic [W-1:0] tx_data;
  logic         tx_busy, tx_done, ser_clk_out, ser_data_out;
  logic         ser_rdy_in, ser_clk_in, ser_data_in, ser_rdy_out;
  logic [W-1:0] rx_data;
  logic         rx_valid, rx_err;
  logic         ext_mode, ext_clk, ext_dat;

  assign ser_clk_in  = ext_mode ? ext_clk : ser_clk_out;
  assign ser_data_in = ext_mode ? ext_dat : ser_data_out;
  assign ser_rdy_in  = ser_rdy_out;

  serial_link_xcvr #(.WIDTH(W), .CLK_DIV(CD), .RX_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .tx_data(tx_data),
    .tx_busy(tx_busy), .tx_done(tx_done),
    .ser_clk_out(ser_clk_out), .ser_data_out(ser_data_out),
    .ser_rdy_in(ser_rdy_in), .ser_clk_in(ser_clk_in), .ser_data_in(ser_data_in),
    .rx_enable(rx_enable), .ser_rdy_out(ser_rdy_out),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_err(rx_err)
  );

  int total = 0;
  int bad   = 0;
  int valid_cnt = 0, err_cnt = 0, done_cnt = 0;
  logic [W-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rx_valid) begin
      valid_cnt++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $error("FAIL rx_unexpected: observed rx_data=%0h expected no frame", rx_data);
      end else begin
        chk("rx_frame", {24'h0, rx_data}, {24'h0, exp_q.pop_front()});
      end
    end
    if (rx_valid || rx_err) chk("valid_err_exclusive", {31'h0, rx_valid & rx_err}, 32'h0);
    if (rx_err) err_cnt++;
    if (tx_done) done_cnt++;
  end

  task automatic send_start(input logic [W-1:0] d);
    tx_data = d;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
  endtask

  task automatic wait_sclk(input string tag);
    int n = 0;
    while (!ser_clk_out && n < 300) begin @(negedge clk); n++; end
    chk(tag, {31'h0, ser_clk_out}, 32'h1);
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!tx_done && n < 300) begin @(negedge clk); n++; end
    chk(tag, {31'h0, tx_done}, 32'h1);
  endtask

  task automatic wait_valid(input string tag, input int v0);
    int n = 0;
    while (valid_cnt == v0 && n < 300) begin @(negedge clk); n++; end
    chk(tag, valid_cnt, v0 + 1);
  endtask

  task automatic send_ext(input logic [W:0] bits, input int nbits, input int lo, input int hi);
    for (int i = 0; i < nbits; i++) begin
      ext_dat = bits[W-i];
      repeat (lo) @(negedge clk);
      ext_clk = 1'b1;
      repeat (hi) @(negedge clk);
      ext_clk = 1'b0;
    end
  endtask

  initial begin
    int n, v0, e0, d0;
    rst = 1'b1; start = 1'b0; rx_enable = 1'b0; tx_data = '0;
    ext_mode = 1'b0; ext_clk = 1'b0; ext_dat = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_ctl", {25'h0, tx_busy, tx_done, ser_clk_out, ser_data_out, ser_rdy_out, rx_valid, rx_err}, 32'h0);
    chk("reset_rx_data", {24'h0, rx_data}, 32'h0);
    rst = 1'b0;

    // loopback A5 with frame latency
    rx_enable = 1'b1;
    repeat (6) @(negedge clk);
    exp_q.push_back(8'hA5);
    v0 = valid_cnt; e0 = err_cnt;
    send_start(8'hA5);
    chk("a5_busy", {31'h0, tx_busy}, 32'h1);
    wait_sclk("a5_sclk_rise");
    n = 0;
    while (!tx_done && n < 300) begin @(negedge clk); n++; end
    chk("a5_done_latency", n, (W + 1) * 2 * CD - CD);
    chk("a5_busy_in_done", {31'h0, tx_busy}, 32'h0);
    wait_valid("a5_valid", v0);
    chk("a5_rx_data", {24'h0, rx_data}, 32'hA5);
    chk("a5_no_err", err_cnt, e0);

    // peer not ready: hold in WAIT_RDY
    rx_enable = 1'b0;
    repeat (6) @(negedge clk);
    d0 = done_cnt; v0 = valid_cnt;
    send_start(8'h3C);
    repeat (20) @(negedge clk);
    chk("3c_wait_busy", {31'h0, tx_busy}, 32'h1);
    chk("3c_wait_sclk", {31'h0, ser_clk_out}, 32'h0);
    chk("3c_wait_nodone", done_cnt, d0);
    exp_q.push_back(8'h3C);
    rx_enable = 1'b1;
    wait_done("3c_done");
    wait_valid("3c_valid", v0);
    chk("3c_rx_data", {24'h0, rx_data}, 32'h3C);

    // start re-asserted mid-frame is ignored
    repeat (4) @(negedge clk);
    d0 = done_cnt; v0 = valid_cnt;
    exp_q.push_back(8'h96);
    send_start(8'h96);
    wait_sclk("96_sclk_rise");
    send_start(8'h11);
    wait_done("96_done");
    wait_valid("96_valid", v0);
    repeat (80) @(negedge clk);
    chk("96_single_done", done_cnt, d0 + 1);
    chk("96_idle_busy", {31'h0, tx_busy}, 32'h0);
    chk("96_rx_data", {24'h0, rx_data}, 32'h96);

    // external driver: bad parity
    ext_mode = 1'b1;
    repeat (4) @(negedge clk);
    v0 = valid_cnt; e0 = err_cnt;
    send_ext({8'h01, 1'b0}, W + 1, 3, 3);
    repeat (10) @(negedge clk);
    chk("par_err_pulse", err_cnt, e0 + 1);
    chk("par_no_valid", valid_cnt, v0);
    chk("par_rx_kept", {24'h0, rx_data}, 32'h96);

    // partial frame then stall past the timeout, then a good frame
    e0 = err_cnt;
    send_ext({8'hF0, 1'b0}, 4, 3, 3);
    repeat (TO + 16) @(negedge clk);
    chk("to_no_pulse", valid_cnt * 16 + err_cnt, v0 * 16 + e0);
    exp_q.push_back(8'hFF);
    send_ext({8'hFF, 1'b0}, W + 1, 3, 3);
    wait_valid("ff_valid", v0);
    chk("ff_rx_data", {24'h0, rx_data}, 32'hFF);
    chk("ff_no_err", err_cnt, e0);

    // slow frame with edge gaps just under the timeout still delivers
    v0 = valid_cnt;
    exp_q.push_back(8'h81);
    send_ext({8'h81, 1'b0}, W + 1, TO - 9, 3);
    wait_valid("slow_valid", v0);
    chk("slow_rx_data", {24'h0, rx_data}, 32'h81);
    ext_mode = 1'b0;
    repeat (4) @(negedge clk);

    // reset mid-SHIFT abandons the frame
    d0 = done_cnt; v0 = valid_cnt; e0 = err_cnt;
    send_start(8'h77);
    wait_sclk("77_sclk_rise");
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_ctl", {25'h0, tx_busy, tx_done, ser_clk_out, ser_data_out, ser_rdy_out, rx_valid, rx_err}, 32'h0);
    chk("midrst_rx_data", {24'h0, rx_data}, 32'h0);
    rst = 1'b0;
    repeat (60) @(negedge clk);
    chk("midrst_no_pulses", (done_cnt - d0) + (valid_cnt - v0) + (err_cnt - e0), 0);
    chk("midrst_idle", {31'h0, tx_busy}, 32'h0);

    v0 = valid_cnt;
    exp_q.push_back(8'h5A);
    send_start(8'h5A);
    wait_done("5a_done");
    wait_valid("5a_valid", v0);
    chk("5a_rx_data", {24'h0, rx_data}, 32'h5A);
    repeat (10) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
